// File: rtl/cpu_if_arbiter.sv
// N-master to 1-slave round-robin arbiter for the pulse-based cpu_if bus.
// One access in flight; a per-access timeout returns TIMEOUT_DATA.
module cpu_if_arbiter #(
    parameter int NUM_MASTERS = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 30,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter logic [DATA_WIDTH-1:0] TIMEOUT_DATA = 32'hDEAD_BEEF
) (
    input  logic clk,
    input  logic reset_n,
    input  logic [NUM_MASTERS-1:0] m_cpu_if_read,
    input  logic [NUM_MASTERS-1:0] m_cpu_if_write,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_cpu_if_address,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_cpu_if_write_data,
    output logic [NUM_MASTERS*DATA_WIDTH-1:0] m_cpu_if_read_data,
    output logic [NUM_MASTERS-1:0] m_cpu_if_access_complete,
    output logic [NUM_MASTERS-1:0] m_timeout,
    output logic [NUM_MASTERS-1:0] m_overrun,
    output logic s_cpu_if_read,
    output logic s_cpu_if_write,
    output logic [ADDR_WIDTH-1:0] s_cpu_if_address,
    output logic [DATA_WIDTH-1:0] s_cpu_if_write_data,
    input  logic [DATA_WIDTH-1:0] s_cpu_if_read_data,
    input  logic s_cpu_if_access_complete
);

    localparam int GW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [GW-1:0] LAST_IDX = GW'(NUM_MASTERS - 1);
    localparam logic [TW-1:0] TIMER_END = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT
    } state_t;

    state_t state;
    logic [NUM_MASTERS-1:0] pending;
    logic [NUM_MASTERS-1:0] is_wr;
    logic [ADDR_WIDTH-1:0] addr_q [NUM_MASTERS];
    logic [DATA_WIDTH-1:0] data_q [NUM_MASTERS];
    logic in_flight;
    logic [GW-1:0] grant;
    logic [GW-1:0] last_grant;
    logic [TW-1:0] timer;

    logic [NUM_MASTERS-1:0] req;
    logic [NUM_MASTERS-1:0] busy;
    logic [GW-1:0] next_sel;

    always_comb begin
        for (int i = 0; i < NUM_MASTERS; i++) begin
            req[i] = m_cpu_if_read[i] | m_cpu_if_write[i];
            busy[i] = pending[i] | (in_flight & (grant == GW'(i)));
        end
    end

    // Scan downwards so the nearest pending index after last_grant wins.
    always_comb begin
        next_sel = '0;
        for (int k = NUM_MASTERS; k >= 1; k--) begin
            if (pending[(int'(last_grant) + k) % NUM_MASTERS]) begin
                next_sel = GW'((int'(last_grant) + k) % NUM_MASTERS);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
            pending <= '0;
            is_wr <= '0;
            for (int i = 0; i < NUM_MASTERS; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
            in_flight <= 1'b0;
            grant <= '0;
            last_grant <= LAST_IDX;
            timer <= '0;
            m_cpu_if_read_data <= '0;
            m_cpu_if_access_complete <= '0;
            m_timeout <= '0;
            m_overrun <= '0;
            s_cpu_if_read <= 1'b0;
            s_cpu_if_write <= 1'b0;
            s_cpu_if_address <= '0;
            s_cpu_if_write_data <= '0;
        end else begin
            m_cpu_if_access_complete <= '0;
            m_timeout <= '0;
            s_cpu_if_read <= 1'b0;
            s_cpu_if_write <= 1'b0;
            m_overrun <= req & busy;

            for (int i = 0; i < NUM_MASTERS; i++) begin
                if (req[i] && !busy[i]) begin
                    pending[i] <= 1'b1;
                    is_wr[i] <= m_cpu_if_write[i];
                    addr_q[i] <= m_cpu_if_address[i*ADDR_WIDTH +: ADDR_WIDTH];
                    if (m_cpu_if_write[i]) begin
                        data_q[i] <= m_cpu_if_write_data[i*DATA_WIDTH +: DATA_WIDTH];
                    end
                end
            end

            unique case (state)
                S_IDLE: begin
                    if (|pending) begin
                        grant <= next_sel;
                        last_grant <= next_sel;
                        s_cpu_if_read <= ~is_wr[next_sel];
                        s_cpu_if_write <= is_wr[next_sel];
                        s_cpu_if_address <= addr_q[next_sel];
                        s_cpu_if_write_data <= data_q[next_sel];
                        state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    pending[grant] <= 1'b0;
                    in_flight <= 1'b1;
                    timer <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    timer <= timer + 1'b1;
                    if (s_cpu_if_access_complete) begin
                        m_cpu_if_access_complete[grant] <= 1'b1;
                        m_cpu_if_read_data[int'(grant)*DATA_WIDTH +: DATA_WIDTH] <=
                            s_cpu_if_read_data;
                        in_flight <= 1'b0;
                        state <= S_IDLE;
                    end else if (timer == TIMER_END) begin
                        m_cpu_if_access_complete[grant] <= 1'b1;
                        m_timeout[grant] <= 1'b1;
                        m_cpu_if_read_data[int'(grant)*DATA_WIDTH +: DATA_WIDTH] <=
                            TIMEOUT_DATA;
                        in_flight <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_if_arbiter.sv
// Self-checking bench for cpu_if_arbiter: directed cases plus random rounds
// checked against a transaction-level round-robin reference model.
module tb_cpu_if_arbiter;

    localparam int N = 4;
    localparam int DW = 32;
    localparam int AW = 30;
    localparam int T = 16;
    localparam logic [DW-1:0] TO_DATA = 32'hDEAD_BEEF;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic [N-1:0] m_read, m_write;
    logic [N*AW-1:0] m_addr;
    logic [N*DW-1:0] m_wdata, m_rdata;
    logic [N-1:0] m_done, m_to, m_ovr;
    logic s_read, s_write, s_done;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_wdata, s_rdata;

    always #5 clk = ~clk;

    cpu_if_arbiter #(
        .NUM_MASTERS(N),
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .TIMEOUT_CYCLES(T),
        .TIMEOUT_DATA(TO_DATA)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .m_cpu_if_read(m_read),
        .m_cpu_if_write(m_write),
        .m_cpu_if_address(m_addr),
        .m_cpu_if_write_data(m_wdata),
        .m_cpu_if_read_data(m_rdata),
        .m_cpu_if_access_complete(m_done),
        .m_timeout(m_to),
        .m_overrun(m_ovr),
        .s_cpu_if_read(s_read),
        .s_cpu_if_write(s_write),
        .s_cpu_if_address(s_addr),
        .s_cpu_if_write_data(s_wdata),
        .s_cpu_if_read_data(s_rdata),
        .s_cpu_if_access_complete(s_done)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_g;
    int ovr_cyc;
    int ovr_m;

    bit rq_wr[N], rq_both[N], ovr[N], stray[N];
    logic [AW-1:0] rq_addr[N];
    logic [DW-1:0] rq_data[N], rq_resp[N], exp_rd[N];
    int lat[N];

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [N*DW-1:0] exp_vec();
        logic [N*DW-1:0] v;
        for (int i = 0; i < N; i++) v[i*DW +: DW] = exp_rd[i];
        return v;
    endfunction

    function automatic logic [N-1:0] onehot(input int m);
        logic [N-1:0] v;
        v = '0;
        v[m] = 1'b1;
        return v;
    endfunction

    function automatic logic [N-1:0] exp_ovr();
        return (cyc == ovr_cyc) ? onehot(ovr_m) : '0;
    endfunction

    task automatic chk_quiet(input string tag);
        chk({tag, "_s"}, 128'({s_read, s_write}), 128'(0));
        chk({tag, "_done"}, 128'({m_done, m_to}), 128'(0));
        chk({tag, "_ovr"}, 128'(m_ovr), 128'(exp_ovr()));
    endtask

    task automatic clear_cfg();
        for (int i = 0; i < N; i++) begin
            rq_wr[i] = 0;
            rq_both[i] = 0;
            ovr[i] = 0;
            stray[i] = 0;
            lat[i] = 0;
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        step();
        last_g = N - 1;
        for (int i = 0; i < N; i++) exp_rd[i] = '0;
    endtask

    // Model: slots pulsed together are served in round-robin order from
    // last_g; each access is ISSUE, then WAIT until slave reply or timeout.
    task automatic do_round(input logic [N-1:0] mask);
        logic [N-1:0] left;
        int j, n;
        logic [DW-1:0] got;
        left = mask;
        ovr_cyc = -1;
        for (int i = 0; i < N; i++) begin
            if (mask[i]) begin
                m_write[i] = rq_wr[i];
                m_read[i] = !rq_wr[i] || rq_both[i];
                m_addr[i*AW +: AW] = rq_addr[i];
                m_wdata[i*DW +: DW] = rq_wr[i] ? rq_data[i] : ~rq_data[i];
            end
        end
        step();
        m_read = '0;
        m_write = '0;
        chk_quiet("gap");
        step();
        while (left != 0) begin
            j = -1;
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (last_g + k) % N;
                if (j < 0 && left[c]) j = c;
            end
            left[j] = 1'b0;
            last_g = j;
            chk("s_rw", 128'({s_read, s_write}), 128'({~rq_wr[j], rq_wr[j]}));
            chk("s_addr", 128'(s_addr), 128'(rq_addr[j]));
            if (rq_wr[j]) chk("s_wdata", 128'(s_wdata), 128'(rq_data[j]));
            chk("issue_done", 128'(m_done), 128'(0));
            if (stray[j]) begin
                s_done = 1'b1;
                s_rdata = $urandom;
            end
            step();
            s_done = 1'b0;
            n = (lat[j] < 0) ? T : lat[j] + 1;
            for (int t = 0; t < n; t++) begin
                s_rdata = $urandom;
                if (t == 0 && ovr[j]) begin
                    m_read[j] = 1'b1;
                    m_addr[j*AW +: AW] = AW'($urandom);
                    ovr_cyc = cyc + 1;
                    ovr_m = j;
                end
                if (t == lat[j]) begin
                    s_done = 1'b1;
                    s_rdata = rq_resp[j];
                end
                step();
                s_done = 1'b0;
                m_read = '0;
                if (t < n - 1) chk_quiet("wait");
            end
            got = (lat[j] < 0) ? TO_DATA : rq_resp[j];
            exp_rd[j] = got;
            chk("done", 128'(m_done), 128'(onehot(j)));
            chk("timeout", 128'(m_to), 128'((lat[j] < 0) ? onehot(j) : '0));
            chk("rdata", 128'(m_rdata), 128'(exp_vec()));
            chk("done_ovr", 128'(m_ovr), 128'(exp_ovr()));
            step();
        end
        chk_quiet("after");
    endtask

    initial begin
        m_read = '0;
        m_write = '0;
        m_addr = '0;
        m_wdata = '0;
        s_rdata = '0;
        s_done = 1'b0;
        ovr_cyc = -1;
        ovr_m = 0;
        clear_cfg();
        repeat (3) step();
        chk("rst_rdata", 128'(m_rdata), 128'(0));
        chk("rst_flags", 128'({m_done, m_to, m_ovr, s_read, s_write}), 128'(0));
        chk("rst_s", 128'({s_addr, s_wdata}), 128'(0));
        do_reset();

        // single read, master 2
        rq_addr[2] = 30'h10;
        rq_resp[2] = 32'h1234_5678;
        lat[2] = 2;
        do_round(4'b0100);

        // all four write together after reset, then rotation
        do_reset();
        for (int i = 0; i < N; i++) begin
            rq_wr[i] = 1;
            rq_addr[i] = AW'(32'h100 + i);
            rq_data[i] = 32'hA000_0000 + i;
            rq_resp[i] = 32'h0;
            lat[i] = 0;
        end
        rq_both[1] = 1;
        do_round(4'b1111);
        do_round(4'b1001);
        do_round(4'b0110);

        // overrun on master 1
        clear_cfg();
        rq_addr[1] = 30'h2A;
        rq_resp[1] = 32'hCAFE_0001;
        lat[1] = 3;
        ovr[1] = 1;
        stray[1] = 1;
        do_round(4'b0010);

        // timeout on master 0, master 1 still pending
        clear_cfg();
        rq_addr[0] = 30'h3;
        lat[0] = -1;
        rq_addr[1] = 30'h4;
        rq_resp[1] = 32'h5555_AAAA;
        lat[1] = 1;
        do_round(4'b0011);

        // completion on the exact timeout cycle
        clear_cfg();
        rq_addr[3] = 30'h77;
        rq_resp[3] = 32'h0BAD_F00D;
        lat[3] = T - 1;
        do_round(4'b1000);

        // reset while in WAIT
        clear_cfg();
        ovr_cyc = -1;
        m_read[1] = 1'b1;
        m_addr[1*AW +: AW] = 30'h55;
        step();
        m_read = '0;
        step();
        chk("pre_rst_issue", 128'({s_read, s_write}), 128'(2'b10));
        repeat (3) step();
        reset_n = 1'b0;
        #1;
        chk("mid_rst_rdata", 128'(m_rdata), 128'(0));
        chk("mid_rst_flags", 128'({m_done, m_to, m_ovr, s_read, s_write}), 128'(0));
        step();
        step();
        reset_n = 1'b1;
        last_g = N - 1;
        for (int i = 0; i < N; i++) exp_rd[i] = '0;
        for (int i = 0; i < T + 8; i++) begin
            step();
            chk_quiet("post_rst");
        end
        rq_addr[0] = 30'h9;
        rq_resp[0] = 32'h1357_9BDF;
        lat[0] = 1;
        do_round(4'b0001);

        // random rounds
        for (int r = 0; r < 40; r++) begin
            logic [N-1:0] mask;
            clear_cfg();
            mask = N'($urandom_range(1, (1 << N) - 1));
            for (int i = 0; i < N; i++) begin
                int sel;
                rq_wr[i] = 1'($urandom);
                rq_both[i] = 1'($urandom);
                rq_addr[i] = AW'($urandom);
                rq_data[i] = $urandom;
                rq_resp[i] = $urandom;
                ovr[i] = ($urandom_range(0, 3) == 0);
                stray[i] = ($urandom_range(0, 3) == 0);
                sel = int'($urandom_range(0, 9));
                if (sel <= 5) lat[i] = sel;
                else if (sel <= 7) lat[i] = int'($urandom_range(0, 3));
                else if (sel == 8) lat[i] = -1;
                else lat[i] = T - 1;
            end
            do_round(mask);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
